// File: rtl/seq_display.sv
// Plays a stored pattern of four colours on one-hot LEDs, one step per flash,
// pacing an external step counter. Optional all-LED finale: SEQ_DISPLAY_ALL_FLASH_EN.
module seq_display #(
  parameter int unsigned SIZE       = 4,
  parameter int unsigned ON_CYCLES  = 25000000,
  parameter int unsigned OFF_CYCLES = 12500000
) (
  input  logic            clk,
  input  logic            R,
  input  logic            new_game,
  input  logic            start,
  input  logic [SIZE-1:0] round,
  input  logic [SIZE-1:0] seq_idx,
  input  logic            end_seq,
  output logic            step_en,
  output logic [3:0]      led,
  output logic            busy,
  output logic            done
);

  localparam int unsigned DEPTH = 2 ** SIZE;
  localparam int unsigned MAXC  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned CW    = (MAXC > 1) ? $clog2(MAXC + 1) : 1;
  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);
  localparam logic [7:0]    LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ON,
    S_OFF,
    S_WAIT,
    S_DONE
`ifdef SEQ_DISPLAY_ALL_FLASH_EN
    , S_FLASH
`endif
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [SIZE-1:0] fill_idx_q;
  logic [7:0]      lfsr_q;
  logic [7:0]      lfsr_d;
  logic [1:0]      mem_q [DEPTH];
  logic [3:0]      led_q;
  logic            step_en_q;
  logic            busy_q;
  logic            done_q;
  logic [3:0]      step_led;
  logic            unused_round;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign step_led = 4'b0001 << mem_q[seq_idx];

  // Playback ends on end_seq alone; round is carried only for visibility.
  assign unused_round = ^round;

  always_ff @(posedge clk) begin
    if (R) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      fill_idx_q <= '0;
      lfsr_q     <= LFSR_SEED;
      led_q      <= '0;
      step_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      lfsr_q    <= lfsr_d;
      step_en_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // Entry 0 is written on the IDLE->FILL edge so it captures the current
          // LFSR value; FILL then writes 1..DEPTH-1 and uses its wrap cycle to exit.
          if (new_game) begin
            mem_q[0]   <= lfsr_q[1:0];
            fill_idx_q <= SIZE'(1);
            busy_q     <= 1'b1;
            state_q    <= S_FILL;
          end else if (start) begin
            led_q   <= step_led;
            cnt_q   <= ON_LOAD;
            busy_q  <= 1'b1;
            state_q <= S_ON;
          end
        end
        S_FILL: begin
          if (fill_idx_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            mem_q[fill_idx_q] <= lfsr_q[1:0];
            fill_idx_q        <= fill_idx_q + 1'b1;
          end
        end
        S_ON: begin
          if (cnt_q == '0) begin
            led_q     <= '0;
            cnt_q     <= OFF_LOAD;
            step_en_q <= (OFF_LOAD == '0);
            state_q   <= S_OFF;
          end else begin
            led_q <= step_led;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_OFF: begin
          if (cnt_q == '0) begin
            state_q <= S_WAIT;
          end else begin
            cnt_q     <= cnt_q - 1'b1;
            step_en_q <= (cnt_q == CW'(1));
          end
        end
        S_WAIT: begin
          if (end_seq) begin
`ifdef SEQ_DISPLAY_ALL_FLASH_EN
            led_q   <= '1;
            cnt_q   <= ON_LOAD;
            state_q <= S_FLASH;
`else
            done_q  <= 1'b1;
            state_q <= S_DONE;
`endif
          end else begin
            led_q   <= step_led;
            cnt_q   <= ON_LOAD;
            state_q <= S_ON;
          end
        end
`ifdef SEQ_DISPLAY_ALL_FLASH_EN
        S_FLASH: begin
          if (cnt_q == '0) begin
            led_q   <= '0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`endif
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          led_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign step_en = step_en_q;
  assign led     = led_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_display.sv
// Directed bench for seq_display with a model of the upstream step counter and
// a queue of expected flash colours filled when playback is started.
module tb_seq_display;

  localparam int unsigned SIZE  = 4;
  localparam int unsigned ON_C  = 3;
  localparam int unsigned OFF_C = 2;
  localparam int unsigned STEP  = ON_C + OFF_C + 1;
`ifdef SEQ_DISPLAY_ALL_FLASH_EN
  localparam int unsigned TAIL = ON_C;
`else
  localparam int unsigned TAIL = 0;
`endif

  logic            clk = 1'b0;
  logic            R;
  logic            new_game;
  logic            start;
  logic [SIZE-1:0] round;
  logic [SIZE-1:0] seq_idx = '0;
  logic            end_seq = 1'b0;
  logic            step_en;
  logic [3:0]      led;
  logic            busy;
  logic            done;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [1:0]  mem_exp [16];
  logic [3:0]  exp_q [$];

  always #5 clk = ~clk;

  seq_display #(
    .SIZE       (SIZE),
    .ON_CYCLES  (ON_C),
    .OFF_CYCLES (OFF_C)
  ) dut (
    .clk      (clk),
    .R        (R),
    .new_game (new_game),
    .start    (start),
    .round    (round),
    .seq_idx  (seq_idx),
    .end_seq  (end_seq),
    .step_en  (step_en),
    .led      (led),
    .busy     (busy),
    .done     (done)
  );

  // Upstream step counter: wraps after index == round and flags end_seq.
  always @(posedge clk) begin
    if (R) begin
      seq_idx <= '0;
      end_seq <= 1'b0;
    end else if (step_en) begin
      if (seq_idx == round) begin
        seq_idx <= '0;
        end_seq <= 1'b1;
      end else begin
        seq_idx <= seq_idx + 1'b1;
        end_seq <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_fill();
    logic [7:0] l;
    l = 8'hA5;
    for (int k = 0; k < 16; k++) begin
      mem_exp[k] = l[1:0];
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
  endtask

  // Reset, then new_game in the first cycle after R falls; count busy cycles.
  task automatic reset_and_fill();
    int unsigned n;
    R = 1'b1;
    @(negedge clk);
    check("rst_led", led, 0);
    check("rst_step_en", step_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    R = 1'b0;
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_fill();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
    check("fill_busy_cycles", n, 16);
  endtask

  task automatic play(input int unsigned r, input bit poke);
    int unsigned t, n_flash, n_step, on_len, all_len, limit;
    bit          got_done, lit, lit_prev;
    round = r[SIZE-1:0];
    start = 1'b1;
    for (int unsigned k = 0; k <= r; k++) exp_q.push_back(4'b0001 << mem_exp[k]);
    @(negedge clk);
    start = 1'b0;
    t = 0; n_flash = 0; n_step = 0; on_len = 0; all_len = 0;
    got_done = 1'b0; lit_prev = 1'b0;
    limit = STEP * (r + 1) + TAIL + 10;
    while (!got_done && t < limit) begin
      if (t == 0) check("busy_on", busy, 1);
`ifdef SEQ_DISPLAY_ALL_FLASH_EN
      if (led == 4'hF) all_len++;
      lit = (led != 4'h0) && (led != 4'hF);
`else
      lit = (led != 4'h0);
`endif
      if (lit && !lit_prev) begin
        check("flash_start_t", t, STEP * n_flash);
        if (exp_q.size() == 0) check("flash_extra", n_flash + 1, r + 1);
        else check("flash_color", led, exp_q.pop_front());
        n_flash++;
        on_len = 0;
      end
      if (lit) on_len++;
      if (!lit && lit_prev) check("flash_len", on_len, ON_C);
      if (step_en) begin
        check("step_en_t", t, STEP * n_step + ON_C + OFF_C - 1);
        n_step++;
      end
      if (done) begin
        check("done_t", t, STEP * (r + 1) + TAIL);
        got_done = 1'b1;
      end
      lit_prev = lit;
      if (poke && t == 1) begin
        start = 1'b1;
        new_game = 1'b1;
      end else if (poke && t == 2) begin
        start = 1'b0;
        new_game = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    check("done_seen", got_done, 1);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("step_count", n_step, r + 1);
    check("flash_count", n_flash, r + 1);
    check("queue_empty", exp_q.size(), 0);
    check("counter_wrapped", seq_idx, 0);
`ifdef SEQ_DISPLAY_ALL_FLASH_EN
    check("all_flash_len", all_len, ON_C);
`endif
    exp_q.delete();
  endtask

  initial begin
    int unsigned n_busy, n_done;
    R = 1'b1;
    new_game = 1'b0;
    start = 1'b0;
    round = '0;
    @(negedge clk);
    reset_and_fill();

    play(2, 1'b0);
    play(0, 1'b0);
    play(2, 1'b1);
    play(1, 1'b0);
    play(5, 1'b0);

    // Reset during the second OFF of a round=2 playback.
    round = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (STEP + ON_C) @(negedge clk);
    R = 1'b1;
    @(negedge clk);
    check("midoff_led", led, 0);
    check("midoff_step_en", step_en, 0);
    check("midoff_busy", busy, 0);
    check("midoff_done", done, 0);
    R = 1'b0;
    n_busy = 0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) n_busy++;
      if (done) n_done++;
      @(negedge clk);
    end
    check("after_rst_busy", n_busy, 0);
    check("after_rst_done", n_done, 0);

    // Memory was cleared by reset: every step shows colour 0.
    for (int k = 0; k < 16; k++) mem_exp[k] = 2'b00;
    play(1, 1'b0);

    reset_and_fill();
    play(3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_display.md
SEQ_DISPLAY -- requirements
Module: seq_display

Interface
REQ-001 The parameter list SHALL be: SIZE, default 4, width of round/index buses; ON_CYCLES, default 25000000, LED-on time per step; OFF_CYCLES, default 12500000, dark gap per step.
REQ-002 The port list SHALL be, in order: clk, input, 1, single clock; all logic on its rising edge.
REQ-003 R, input, 1: reset, synchronous and active-high.
REQ-004 new_game, input, 1: one-cycle request to generate a fresh color pattern.
REQ-005 start, input, 1: one-cycle request to play the current round.
REQ-006 round, input, SIZE: index of the last step to show; round+1 steps are played.
REQ-007 seq_idx, input, SIZE: current step index from the upstream step counter.
REQ-008 end_seq, input, 1: last-step-passed flag from the upstream step counter.
REQ-009 step_en, output, 1: one-cycle advance pulse to the step counter's enable.
REQ-010 led, output, 4: one-hot color; 4'b0000 means dark.
REQ-011 busy, output, 1: high in every state except IDLE.
REQ-012 done, output, 1: one-cycle pulse when playback completes.

Function
REQ-013 The pattern memory SHALL hold 2^SIZE entries of 2 bits each, giving colors 0 to 3.
REQ-014 An 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, SHALL shift every cycle; seed 8'hA5.
REQ-015 The FSM states SHALL be IDLE, FILL, ON, OFF, WAIT and DONE.
REQ-016 IDLE + new_game SHALL go to FILL; FILL writes lfsr[1:0] into mem[k], k=0..2^SIZE-1, one per cycle, then returns to IDLE.
REQ-017 IDLE + start, with new_game low, SHALL go to ON; new_game has priority if both are high.
REQ-018 start and new_game SHALL be ignored outside IDLE.
REQ-019 ON SHALL last exactly ON_CYCLES cycles with led = 4'b0001 << mem[seq_idx].
REQ-020 OFF SHALL last exactly OFF_CYCLES cycles with led = 0; step_en SHALL pulse on OFF's final cycle.
REQ-021 WAIT SHALL last one cycle so the counter can update; then go to DONE if end_seq = 1, else to ON.
REQ-022 DONE SHALL last one cycle with done = 1, then go to IDLE.
REQ-023 The block SHALL make no comparison against round itself; termination is by end_seq only; round is passed through for documentation and bench checks.
REQ-024 The dwell counter SHALL be wide enough for max(ON_CYCLES, OFF_CYCLES); it reloads on every state entry.
REQ-025 step_en SHALL be high for exactly one cycle per step; no step_en in IDLE, FILL or DONE.
REQ-026 A step with seq_idx = round makes the counter wrap to 0 and raise end_seq; that SHALL terminate playback after round+1 flashes.

Reset
REQ-027 R = 1 at a clock edge SHALL force state IDLE, led 0, step_en 0, busy 0, done 0, dwell counter 0, LFSR 8'hA5, all memory entries 0.
REQ-028 R SHALL override all other inputs, including in mid-ON, mid-OFF or mid-FILL; there is no partial completion and no done pulse.

Configuration
REQ-029 With macro SEQ_DISPLAY_ALL_FLASH_EN defined, WAIT with end_seq = 1 SHALL enter a FLASH state lasting ON_CYCLES with led = 4'b1111, then go to DONE.
REQ-030 Without SEQ_DISPLAY_ALL_FLASH_EN, the FLASH state and its logic SHALL be absent and WAIT goes directly to DONE.

Verification (ON_CYCLES=3, OFF_CYCLES=2, SIZE=4, bench counter model of the upstream step counter)
REQ-031 Reset, then new_game in the first cycle after R falls -> busy for 16 cycles; mem[0] = 2'b01 (from 8'hA5); later start -> first flash led = 4'b0010.
REQ-032 round=2, start -> 3 flashes of 3 cycles each; 3 step_en pulses 6 cycles apart; done 18 cycles after ON entry (macro off); counter back at 0.
REQ-033 round=0 -> single flash, single step_en, done after 6 cycles.
REQ-034 start and new_game pulsed during ON -> ignored; the playback sequence is unchanged.
REQ-035 R asserted during second OFF -> next cycle all outputs 0, state IDLE, no done pulse.
REQ-036 Macro defined, round=1 -> after 2 flashes, led = 4'b1111 for 3 cycles, then done.
